// File: rtl/seq_det_ctrl_if.sv
// seq_det_ctrl_if
//   Bundles the configuration, control, serial-data and status signals of
//   seq_det_ctrl. clk and rst stay plain ports on the controller.
//
//   Handshake: there is no ready/back-pressure. din is consumed on every
//   rising edge where din_valid is high and the controller is in RUN.
//   Beats presented in any other state are dropped. cfg_we and start are
//   single-cycle commands that are only acted on in IDLE.
//
//   master : host side (drives cfg_*, start, abort, din_valid, din)
//   slave  : controller side (drives busy, dout, done, match_cnt, cfg_err,
//            state)
interface seq_det_ctrl_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
);
  localparam int LEN_W = $clog2(PAT_W) + 1;

  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_target;
  logic             start;
  logic             abort;
  logic             din_valid;
  logic             din;
  logic             busy;
  logic             dout;
  logic             done;
  logic [CNT_W-1:0] match_cnt;
  logic             cfg_err;
  logic [1:0]       state;      // debug view of the controller FSM

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    output start, abort, din_valid, din,
    input  busy, dout, done, match_cnt, cfg_err, state
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    input  start, abort, din_valid, din,
    output busy, dout, done, match_cnt, cfg_err, state
  );
endinterface

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl
//   Programmable serial pattern-detection controller. A host loads a
//   pattern (up to PAT_W bits), its length, an overlap mode and a target
//   match count while IDLE, then starts a run. In RUN every qualified din
//   beat is shifted in and compared against the pattern; each match
//   produces a one-cycle dout pulse and bumps match_cnt. Reaching the
//   target passes through a one-cycle DONE state (done pulse) back to IDLE.
//
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous, active-low reset
//   bus  : seq_det_ctrl_if.slave (config, start/abort, din stream, status,
//          debug FSM state)
//
// All outputs are registered.
module seq_det_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  seq_det_ctrl_if.slave bus
);

  localparam int LEN_W = $clog2(PAT_W) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

  logic [1:0]       state_q;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [CNT_W-1:0] tgt_q;
  // Only the low PAT_W-1 history bits are stored; together with the
  // incoming din they form the full PAT_W-bit compare window.
  logic [PAT_W-2:0] shift_q;
  logic [LEN_W-1:0] fill_q;
  logic             busy_q;
  logic             dout_q;
  logic             done_q;
  logic [CNT_W-1:0] match_cnt_q;
  logic             cfg_err_q;

  logic [PAT_W-1:0] new_shift;
  logic [PAT_W-1:0] len_mask;
  logic [LEN_W-1:0] fill_inc;
  logic [CNT_W-1:0] cnt_inc;
  logic             hit;
  logic             cfg_in_ok;
  logic             cfg_reg_ok;

  always_comb begin
    new_shift = {shift_q, bus.din};
    fill_inc  = (fill_q >= MAX_LEN) ? MAX_LEN : fill_q + 1'b1;
    len_mask  = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
    // Window must hold at least len fresh bits before a compare counts.
    hit        = (fill_inc >= len_q) && (((new_shift ^ pat_q) & len_mask) == '0);
    cnt_inc    = match_cnt_q + 1'b1;
    cfg_in_ok  = (bus.cfg_len != '0) && (bus.cfg_len <= MAX_LEN) &&
                 (bus.cfg_target != '0);
    cfg_reg_ok = (len_q != '0) && (len_q <= MAX_LEN) && (tgt_q != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
      tgt_q       <= '0;
      shift_q     <= '0;
      fill_q      <= '0;
      busy_q      <= 1'b0;
      dout_q      <= 1'b0;
      done_q      <= 1'b0;
      match_cnt_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      dout_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A config write shadows a coincident start.
          if (bus.cfg_we) begin
            pat_q     <= bus.cfg_pattern;
            len_q     <= bus.cfg_len;
            ovl_q     <= bus.cfg_overlap;
            tgt_q     <= bus.cfg_target;
            cfg_err_q <= !cfg_in_ok;
          end else if (bus.start) begin
            if (cfg_reg_ok) begin
              shift_q     <= '0;
              fill_q      <= '0;
              match_cnt_q <= '0;
              cfg_err_q   <= 1'b0;
              busy_q      <= 1'b1;
              state_q     <= RUN;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          // abort discards the coincident beat, including a completing match.
          if (bus.abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (bus.din_valid) begin
            shift_q <= new_shift[PAT_W-2:0];
            if (hit) begin
              match_cnt_q <= cnt_inc;
              dout_q      <= 1'b1;
              // Non-overlap mode restarts the fill so no bit is reused.
              fill_q      <= ovl_q ? fill_inc : '0;
              if (cnt_inc == tgt_q) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= DONE;
              end
            end else begin
              fill_q <= fill_inc;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.dout      = dout_q;
  assign bus.done      = done_q;
  assign bus.match_cnt = match_cnt_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.state     = state_q;

endmodule
